position_update_controller: RTL
===============================

# position_update_controller

Phase-2 counterpart of the force/velocity phase: walks one cell's particle list, reads each position record and its velocity record, and writes the integrated position `p + (v >>> DT_SHIFT)` into the opposite position buffer. It mirrors the phase-1 arrangement in reverse: phase 1 reads position caches and writes velocity caches, while this block reads velocity caches and writes position caches. The top level instantiates one per cell, and their `CTL_DONE` outputs are AND-reduced.

## Interface
- `DEPTH`, default 256: records per position buffer. Buffer A spans addresses `[0, DEPTH)`; buffer B spans `[DEPTH, 2*DEPTH)`.
- `DT_SHIFT`, default 4: timestep expressed as an arithmetic right shift applied to velocity.
- `BOX`, default 32'h0100_0000: periodic box length in fixed-point units. Used only with `POS_WRAP_EN`.
- `clk`  in  1  single clock. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high.
- `CTL_READY`  in  1  start pulse.
- `CTL_DOUBLE_BUFFER`  in  1  buffer select: 0 = read A, write B; 1 = read B, write A.
- `CTL_DONE`  out  1  level; high from the run's end until the next accepted start.
- `busy`  out  1  high while a run is active.
- `p_iaddr`  out  32  position read address.
- `r_p_cache`  in  97  position record; valid one cycle after address.
- `v_iaddr`  out  32  velocity read address (`0..DEPTH-1`, unbuffered).
- `r_v_cache`  in  97  velocity record; valid one cycle after address.
- `p_oaddr`  out  32  position write address.
- `w_p_cache`  out  97  position write data.
- `p_wr_en`  out  1  write strobe.
- `count`  out  32  number of valid particles written in the last run.

## Operation
- Record layout: bit [96] = null flag (1 = empty slot / end of list); [95:64] z; [63:32] y; [31:0] x. Each coordinate is a signed 32-bit fixed-point value. The null record is all ones.
- States:
  - IDLE: waits for a start.
  - RUN: issues reads.
  - DRAIN: completes the final write.
  - DONE: holds `CTL_DONE`.
- IDLE/DONE -> RUN on `CTL_READY`:
  - `CTL_DOUBLE_BUFFER` is latched into `db`.
  - `idx` and `count` are cleared.
  - `CTL_DONE` falls.
- Read bases: `rbase = db ? DEPTH : 0`; `wbase = db ? 0 : DEPTH`.
- RUN issues, per cycle, `p_iaddr = rbase+idx` and `v_iaddr = idx`, then increments `idx`.
- Returned record handling:
  - Valid (`r_p_cache[96]==0`): write `{1'b0, z', y', x'}` at `wbase` plus the record's index, and increment `count`.
  - Null: write the null record at that index, stop issuing reads, discard the one in-flight read, and go to DRAIN.
- If `idx` reaches DEPTH with no null seen, go to DRAIN after the last issue. No null record is written in that case.
- Coordinate update: `c' = c + (v_c >>> DT_SHIFT)`. The shift is arithmetic. The sum wraps modulo 2^32 (no saturation).
- DRAIN -> DONE once the final write has been issued.
- `CTL_READY` in RUN or DRAIN is ignored.
- `CTL_DOUBLE_BUFFER` changes mid-run are ignored.
- Velocity null bit: ignored.

## Timing
- Latency from address issue to `p_wr_en` is 2 cycles: BRAM read (1) plus output register (1).
- Throughput: 1 record/cycle.
- A list with n valid records followed by a null record takes n+1 writes. `CTL_DONE` rises 3 cycles after the null record's address was issued.
- A full list (DEPTH records) asserts `CTL_DONE` 3 cycles after the last issue.
- Values during reset and in IDLE:
  - `p_iaddr`, `v_iaddr`, `p_oaddr` = 0.
  - `p_wr_en` = 0.
  - `w_p_cache` = all ones.
  - `count` = 0.
  - `CTL_DONE` = 0.
  - `busy` = 0.
- Reset asserted mid-run: state returns to IDLE immediately and `p_wr_en` drops the same instant. Partial writes are not rolled back.
- `p_wr_en` is high for exactly one cycle per written record. It is never high outside RUN/DRAIN.

## Configuration
- `POS_WRAP_EN` defined: each updated coordinate is folded into `[0, BOX)`.
  - If `c' >= BOX`, subtract BOX.
  - If `c' < 0`, add BOX.
  - At most one fold is applied; the design requires `|v >>> DT_SHIFT| < BOX`.
- `POS_WRAP_EN` undefined: no fold, plain two's-complement wrap. BOX is unused.

## Structure
- Shared package `md_pkg` holds:
  - `REC_W = 97`;
  - field offsets `X_LSB`, `Y_LSB`, `Z_LSB`, `NULL_BIT`;
  - `NULL_REC`;
  - the state enum.
- One sub-module, `coord_update`: a 32-bit shift, add, and optional fold. It is instantiated three times, for x, y and z.

## Test plan
- `DT_SHIFT=4`, db=0, record 0 = (x=0x100, y=0x200, z=0x300) with v=(0x10,0x20,-0x10), record 1 null -> writes at addr 256 `{0,0x2FF,0x202,0x101}`, then the null record at addr 257; `count`=1; `CTL_DONE` high.
- db=1, 3 valid records then null -> reads at 256..259, writes at 0..3; `count`=3.
- DEPTH=4, all 4 valid -> 4 writes, no null write, `CTL_DONE` 3 cycles after the last issue.
- `POS_WRAP_EN`, BOX=0x1000, x=0xFF8, vx=0x100 (`DT_SHIFT=4`) -> x'=0x8; x=0x4, vx=-0x100 -> x'=0xFF4.
- Reset asserted on the 2nd write of a 5-record run -> outputs return to their reset values, and a fresh `CTL_READY` restarts at idx 0.
- `CTL_READY` pulsed mid-run -> ignored; `count` and addresses are unchanged.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and record layout for the MD position/velocity phases.
// Optional POS_WRAP_EN folds updated coordinates back into the periodic box.
package md_pkg;
    localparam int REC_W    = 97;
    localparam int X_LSB    = 0;
    localparam int Y_LSB    = 32;
    localparam int Z_LSB    = 64;
    localparam int NULL_BIT = 96;

    localparam logic [REC_W-1:0] NULL_REC = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

`ifdef POS_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
endpackage

// File: rtl/position_update_controller_if.sv
// Cache-side bus of the position update controller: position/velocity reads
// and the position write port.
interface position_update_controller_if;
    import md_pkg::*;

    logic [31:0]      p_iaddr;
    logic [REC_W-1:0] r_p_cache;
    logic [31:0]      v_iaddr;
    logic [REC_W-1:0] r_v_cache;
    logic [31:0]      p_oaddr;
    logic [REC_W-1:0] w_p_cache;
    logic             p_wr_en;

    modport master (
        output p_iaddr, v_iaddr, p_oaddr, w_p_cache, p_wr_en,
        input  r_p_cache, r_v_cache
    );

    modport slave (
        input  p_iaddr, v_iaddr, p_oaddr, w_p_cache, p_wr_en,
        output r_p_cache, r_v_cache
    );
endinterface

// File: rtl/position_update_controller_coord_update.sv
// One coordinate step: c + (v >>> DT_SHIFT), wrapping mod 2^32, with an
// optional single fold into [0, BOX) when POS_WRAP_EN is defined.
module coord_update
    import md_pkg::*;
#(
    parameter int          DT_SHIFT = 4,
    parameter logic [31:0] BOX      = 32'h0100_0000
) (
    input  logic [31:0] c,
    input  logic [31:0] v,
    output logic [31:0] c_new
);
    logic signed [31:0] sum;

    always_comb begin
        sum   = $signed(c) + ($signed(v) >>> DT_SHIFT);
        c_new = sum;
        // one fold is enough because |v >>> DT_SHIFT| < BOX
        if (WRAP_EN) begin
            if (sum >= $signed(BOX))
                c_new = sum - BOX;
            else if (sum < 0)
                c_new = sum + BOX;
        end
    end
endmodule

// File: rtl/position_update_controller.sv
// Phase-2 integrator: walks a cell's particle list and writes p + (v >>> DT_SHIFT)
// into the opposite position buffer. POS_WRAP_EN enables periodic folding.
module position_update_controller
    import md_pkg::*;
#(
    parameter int          DEPTH    = 256,
    parameter int          DT_SHIFT = 4,
    parameter logic [31:0] BOX      = 32'h0100_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         CTL_READY,
    input  logic                         CTL_DOUBLE_BUFFER,
    output logic                         CTL_DONE,
    output logic                         busy,
    output logic [31:0]                  count,
    position_update_controller_if.master mem
);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t           state;
    logic             db;
    logic [31:0]      idx, rd_idx, rbase, wbase;
    logic [1:0]       vld_pipe;  // [0] read data returning, [1] write strobe
    logic [REC_W-1:0] upd_rec;
    logic             unused_vnull;

    assign rbase        = db ? DEPTH_W : '0;
    assign wbase        = db ? '0 : DEPTH_W;
    assign busy         = (state == S_RUN) || (state == S_DRAIN);
    assign mem.p_iaddr  = (state == S_RUN) ? rbase + idx : '0;
    assign mem.v_iaddr  = (state == S_RUN) ? idx : '0;
    assign mem.p_wr_en  = vld_pipe[1];
    assign unused_vnull = mem.r_v_cache[NULL_BIT];

    for (genvar g = 0; g < 3; g++) begin : g_coord
        localparam int LSB = (g == 0) ? X_LSB : (g == 1) ? Y_LSB : Z_LSB;
        coord_update #(.DT_SHIFT(DT_SHIFT), .BOX(BOX)) u_coord (
            .c     (mem.r_p_cache[LSB +: 32]),
            .v     (mem.r_v_cache[LSB +: 32]),
            .c_new (upd_rec[LSB +: 32])
        );
    end
    assign upd_rec[NULL_BIT] = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            db            <= 1'b0;
            idx           <= '0;
            rd_idx        <= '0;
            vld_pipe      <= '0;
            count         <= '0;
            CTL_DONE      <= 1'b0;
            mem.p_oaddr   <= '0;
            mem.w_p_cache <= NULL_REC;
        end else begin
            vld_pipe      <= '0;
            mem.p_oaddr   <= '0;
            mem.w_p_cache <= NULL_REC;

            // returning record is written back the same way in RUN and DRAIN
            if (busy && vld_pipe[0]) begin
                vld_pipe[1] <= 1'b1;
                mem.p_oaddr <= wbase + rd_idx;
                if (!mem.r_p_cache[NULL_BIT]) begin
                    mem.w_p_cache <= upd_rec;
                    count         <= count + 1'b1;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (CTL_READY) begin
                        state    <= S_RUN;
                        db       <= CTL_DOUBLE_BUFFER;
                        idx      <= '0;
                        count    <= '0;
                        CTL_DONE <= 1'b0;
                    end
                end
                S_RUN: begin
                    // on a null the read issued this cycle is dropped
                    if (vld_pipe[0] && mem.r_p_cache[NULL_BIT]) begin
                        state <= S_DRAIN;
                    end else begin
                        vld_pipe[0] <= 1'b1;
                        rd_idx      <= idx;
                        idx         <= idx + 1'b1;
                        if (idx == DEPTH_W - 1'b1)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!vld_pipe[0]) begin
                        state    <= S_DONE;
                        CTL_DONE <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
